fb_arbiter: RTL and testbench

Frame-buffer port arbiter sharing one single-port synchronous video memory between the VGA scanout read path and a pixel-writer (keyboard/text renderer, test pattern generator). Scanout has priority. Writer traffic is buffered in a small write FIFO and drained into memory cycles that scanout does not use. The block sits between `vga_ctrl`'s pixel address and the frame-buffer RAM, replacing a direct combinational ROM lookup.

---
 rtl/fb_pkg.sv | 18 +
 rtl/fb_wfifo.sv | 63 ++++++
 rtl/fb_arbiter.sv | 167 ++++++++++++++++
 tb/tb_fb_arbiter.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/fb_pkg.sv
// Shared types for the frame-buffer arbiter slice: address/pixel widths,
// their typedefs and the per-cycle memory grant encoding.
package fb_pkg;

  localparam int AW = 19;
  localparam int DW = 24;

  typedef logic [AW-1:0] fb_addr_t;
  typedef logic [DW-1:0] fb_pixel_t;

  typedef enum logic [1:0] {
    GNT_IDLE,
    GNT_SCAN,
    GNT_WRITE,
    GNT_FORCE
  } fb_gnt_e;

endpackage

// File: rtl/fb_wfifo.sv
// Small synchronous write FIFO with a first-word-fall-through head.
// Pointers carry one extra wrap bit so full and empty are told apart
// without a separate occupancy counter. Push when full and pop when
// empty are ignored.
module fb_wfifo
  import fb_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int W     = AW + DW
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic [W-1:0] push_data,
  input  logic         pop,
  output logic [W-1:0] head,
  output logic         full,
  output logic         empty
);

  localparam int PW = $clog2(DEPTH);

  logic [PW:0]  wr_ptr_q, wr_ptr_d;
  logic [PW:0]  rd_ptr_q, rd_ptr_d;
  logic [W-1:0] mem_q [DEPTH];
  logic [W-1:0] mem_d [DEPTH];

  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[PW] != rd_ptr_q[PW]) &&
                 (wr_ptr_q[PW-1:0] == rd_ptr_q[PW-1:0]);
  assign head  = mem_q[rd_ptr_q[PW-1:0]];

  // Next pointer and storage values for accepted pushes and pops
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    mem_d    = mem_q;
    if (push && !full) begin
      mem_d[wr_ptr_q[PW-1:0]] = push_data;
      wr_ptr_d                = wr_ptr_q + 1'b1;
    end
    if (pop && !empty) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
  end

  // Pointer registers; reset empties the FIFO and drops any queued entries
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Entry storage needs no reset: only slots between the pointers are read
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

endmodule

// File: rtl/fb_arbiter.sv
// Frame-buffer port arbiter: scanout reads own the single-port memory
// whenever they ask; writer traffic is queued in fb_wfifo and drained in
// the gaps. Optional macro FB_ARB_STARVE_EN lets a writer that has waited
// MAX_WAIT cycles steal one scanout slot (the scanout pixel is repeated)
// and counts those events in underrun_cnt.
module fb_arbiter
  import fb_pkg::*;
#(
  parameter int AW         = fb_pkg::AW,
  parameter int DW         = fb_pkg::DW,
  parameter int WBUF_DEPTH = 4,
  parameter int MAX_WAIT   = 64
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          sc_req,
  input  logic [AW-1:0] sc_addr,
  output logic          sc_valid,
  output logic [DW-1:0] sc_data,
  input  logic          wr_valid,
  output logic          wr_ready,
  input  logic [AW-1:0] wr_addr,
  input  logic [DW-1:0] wr_data,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  output logic [15:0]   underrun_cnt
);

  localparam int WAIT_W = $clog2(MAX_WAIT + 1);

`ifdef FB_ARB_STARVE_EN
  localparam bit STARVE_EN = 1'b1;
`else
  localparam bit STARVE_EN = 1'b0;
`endif

  fb_gnt_e          gnt;
  logic             fifo_full, fifo_empty;
  logic             push, pop;
  logic [AW+DW-1:0] head;
  logic [AW-1:0]    head_addr;
  logic [DW-1:0]    head_data;
  logic             starve;

  logic              sc_valid_q, sc_valid_d;
  logic              was_scan_q, was_scan_d;
  logic [DW-1:0]     pix_q, pix_d;
  logic [WAIT_W-1:0] wait_q, wait_d;

  assign {head_addr, head_data} = head;
  assign wr_ready = !rst && !fifo_full;
  assign push     = wr_valid && wr_ready;
  assign starve   = STARVE_EN && (wait_q == WAIT_W'(MAX_WAIT));

  fb_wfifo #(
    .DEPTH (WBUF_DEPTH),
    .W     (AW + DW)
  ) u_wfifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data ({wr_addr, wr_data}),
    .pop       (pop),
    .head      (head),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  // Per-cycle grant: reset blocks all access, scanout wins unless starved
  always_comb begin
    gnt = GNT_IDLE;
    if (!rst) begin
      if (sc_req && starve && !fifo_empty) begin
        gnt = GNT_FORCE;
      end else if (sc_req) begin
        gnt = GNT_SCAN;
      end else if (!fifo_empty) begin
        gnt = GNT_WRITE;
      end
    end
  end

  // Memory port drive and FIFO pop follow directly from the grant
  always_comb begin
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    pop       = 1'b0;
    unique case (gnt)
      GNT_SCAN: begin
        mem_en   = 1'b1;
        mem_addr = sc_addr;
      end
      GNT_WRITE, GNT_FORCE: begin
        mem_en    = 1'b1;
        mem_we    = 1'b1;
        mem_addr  = head_addr;
        mem_wdata = head_data;
        pop       = 1'b1;
      end
      default: begin
      end
    endcase
  end

  // Scanout result path and writer wait counter next-state
  always_comb begin
    sc_valid_d = (gnt == GNT_SCAN) || (gnt == GNT_FORCE);
    was_scan_d = (gnt == GNT_SCAN);
    pix_d      = was_scan_q ? mem_rdata : pix_q;
    wait_d     = wait_q;
    if (pop) begin
      wait_d = '0;
    end else if (!fifo_empty && (wait_q != WAIT_W'(MAX_WAIT))) begin
      wait_d = wait_q + 1'b1;
    end
  end

  // sc_data shows fresh RAM data the cycle after a read, otherwise the held pixel
  assign sc_valid = sc_valid_q;
  assign sc_data  = pix_d;

  // Arbiter state registers
  always_ff @(posedge clk) begin
    if (rst) begin
      sc_valid_q <= 1'b0;
      was_scan_q <= 1'b0;
      pix_q      <= '0;
      wait_q     <= '0;
    end else begin
      sc_valid_q <= sc_valid_d;
      was_scan_q <= was_scan_d;
      pix_q      <= pix_d;
      wait_q     <= wait_d;
    end
  end

`ifdef FB_ARB_STARVE_EN
  logic [15:0] underrun_q, underrun_d;

  // Saturating count of forced writer grants
  always_comb begin
    underrun_d = underrun_q;
    if ((gnt == GNT_FORCE) && (underrun_q != 16'hFFFF)) begin
      underrun_d = underrun_q + 16'd1;
    end
  end

  // Underrun counter register
  always_ff @(posedge clk) begin
    if (rst) begin
      underrun_q <= '0;
    end else begin
      underrun_q <= underrun_d;
    end
  end

  assign underrun_cnt = underrun_q;
`else
  assign underrun_cnt = '0;
`endif

endmodule

// File: tb/tb_fb_arbiter.sv
// Directed testbench for fb_arbiter with a behavioural synchronous RAM
// model standing in for the frame buffer. Starvation checks follow the
// FB_ARB_STARVE_EN macro the design is built with.
module tb_fb_arbiter;

  localparam int AW = 19;
  localparam int DW = 24;

  logic          clk;
  logic          rst;
  logic          sc_req;
  logic [AW-1:0] sc_addr;
  logic          sc_valid;
  logic [DW-1:0] sc_data;
  logic          wr_valid;
  logic          wr_ready;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;
  logic          mem_en;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;
  logic [15:0]   underrun_cnt;

  int total_checks;
  int bad_checks;

  logic [DW-1:0] ram [logic [AW-1:0]];

  fb_arbiter #(
    .AW         (AW),
    .DW         (DW),
    .WBUF_DEPTH (4),
    .MAX_WAIT   (64)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .sc_req       (sc_req),
    .sc_addr      (sc_addr),
    .sc_valid     (sc_valid),
    .sc_data      (sc_data),
    .wr_valid     (wr_valid),
    .wr_ready     (wr_ready),
    .wr_addr      (wr_addr),
    .wr_data      (wr_data),
    .mem_en       (mem_en),
    .mem_we       (mem_we),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .mem_rdata    (mem_rdata),
    .underrun_cnt (underrun_cnt)
  );

  // Free-running clock, period 10
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Single-port synchronous RAM: write on we, registered read data otherwise
  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) begin
        ram[mem_addr] = mem_wdata;
      end else begin
        mem_rdata <= ram.exists(mem_addr) ? ram[mem_addr] : '0;
      end
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total_checks++;
    if (got !== exp) begin
      bad_checks++;
      $display("[TB] FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Drive one cycle's inputs just after the clock edge and let them settle
  task automatic applyStimulus(input logic req, input logic [AW-1:0] saddr,
                               input logic wv, input logic [AW-1:0] waddr,
                               input logic [DW-1:0] wdata);
    sc_req   = req;
    sc_addr  = saddr;
    wr_valid = wv;
    wr_addr  = waddr;
    wr_data  = wdata;
    #1;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic seen_we;
    logic seen_en;

    total_checks = 0;
    bad_checks   = 0;
    ram[19'h00005] = 24'hABCDEF;
    mem_rdata = '0;
    rst = 1'b1;
    applyStimulus(1'b0, '0, 1'b0, '0, '0);

    // Reset behaviour
    next_cycle();
    next_cycle();
    applyStimulus(1'b1, 19'h00005, 1'b1, 19'h00099, 24'h999999);
    checkOutput("rst_wr_ready", 32'(wr_ready), 32'd0);
    checkOutput("rst_mem_en", 32'(mem_en), 32'd0);
    checkOutput("rst_mem_addr", 32'(mem_addr), 32'd0);
    checkOutput("rst_sc_valid", 32'(sc_valid), 32'd0);
    checkOutput("rst_sc_data", 32'(sc_data), 32'd0);
    checkOutput("rst_underrun", 32'(underrun_cnt), 32'd0);
    next_cycle();
    rst = 1'b0;
    applyStimulus(1'b0, '0, 1'b0, '0, '0);
    checkOutput("idle_wr_ready", 32'(wr_ready), 32'd1);
    checkOutput("idle_sc_valid", 32'(sc_valid), 32'd0);
    checkOutput("idle_mem_en", 32'(mem_en), 32'd0);
    checkOutput("idle_underrun", 32'(underrun_cnt), 32'd0);
    next_cycle();

    // Scanout only
    applyStimulus(1'b1, 19'h00005, 1'b0, '0, '0);
    checkOutput("scan_mem_en", 32'(mem_en), 32'd1);
    checkOutput("scan_mem_we", 32'(mem_we), 32'd0);
    checkOutput("scan_mem_addr", 32'(mem_addr), 32'h00005);
    next_cycle();
    applyStimulus(1'b0, '0, 1'b0, '0, '0);
    checkOutput("scan_sc_valid", 32'(sc_valid), 32'd1);
    checkOutput("scan_sc_data", 32'(sc_data), 32'hABCDEF);
    next_cycle();
    applyStimulus(1'b0, '0, 1'b0, '0, '0);
    checkOutput("scan_valid_drop", 32'(sc_valid), 32'd0);
    checkOutput("scan_data_hold", 32'(sc_data), 32'hABCDEF);
    next_cycle();

    // Write in a scanout gap, then read it back
    applyStimulus(1'b0, '0, 1'b1, 19'h00010, 24'h123456);
    checkOutput("gap_accept_ready", 32'(wr_ready), 32'd1);
    checkOutput("gap_no_same_cycle_write", 32'(mem_en), 32'd0);
    next_cycle();
    applyStimulus(1'b0, '0, 1'b0, '0, '0);
    checkOutput("gap_mem_we", 32'(mem_we), 32'd1);
    checkOutput("gap_mem_addr", 32'(mem_addr), 32'h00010);
    checkOutput("gap_mem_wdata", 32'(mem_wdata), 32'h123456);
    next_cycle();
    applyStimulus(1'b1, 19'h00010, 1'b0, '0, '0);
    checkOutput("gap_fifo_drained", 32'(mem_we), 32'd0);
    next_cycle();
    applyStimulus(1'b0, '0, 1'b0, '0, '0);
    checkOutput("gap_readback", 32'(sc_data), 32'h123456);
    next_cycle();

    // Fill the FIFO behind continuous scanout
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b1, '0, 1'b1, AW'(19'h00100 + i), DW'(24'h0A0000 + i));
      checkOutput($sformatf("fill_ready_%0d", i), 32'(wr_ready), 32'd1);
      checkOutput($sformatf("fill_no_write_%0d", i), 32'(mem_we), 32'd0);
      next_cycle();
    end
    applyStimulus(1'b1, '0, 1'b1, 19'h001FF, 24'hDEAD00);
    checkOutput("full_wr_ready", 32'(wr_ready), 32'd0);
    checkOutput("full_mem_we", 32'(mem_we), 32'd0);
    next_cycle();
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b0, '0, 1'b0, '0, '0);
      checkOutput($sformatf("drain_we_%0d", i), 32'(mem_we), 32'd1);
      checkOutput($sformatf("drain_addr_%0d", i), 32'(mem_addr), 32'h00100 + i);
      checkOutput($sformatf("drain_data_%0d", i), 32'(mem_wdata), 32'h0A0000 + i);
      checkOutput($sformatf("drain_ready_%0d", i), 32'(wr_ready), (i == 0) ? 32'd0 : 32'd1);
      next_cycle();
    end
    applyStimulus(1'b0, '0, 1'b0, '0, '0);
    checkOutput("full_reject_not_queued", 32'(mem_en), 32'd0);
    next_cycle();

    // Starvation: one write pending under continuous scanout
    applyStimulus(1'b1, 19'h00005, 1'b1, 19'h00020, 24'h555555);
    checkOutput("starve_accept", 32'(wr_ready), 32'd1);
    next_cycle();
    seen_we = 1'b0;
    for (int i = 1; i <= 64; i++) begin
      applyStimulus(1'b1, 19'h00005, 1'b0, '0, '0);
      if (mem_we) seen_we = 1'b1;
      next_cycle();
    end
    checkOutput("starve_no_early_write", 32'(seen_we), 32'd0);
    applyStimulus(1'b1, 19'h00010, 1'b0, '0, '0);
`ifdef FB_ARB_STARVE_EN
    checkOutput("force_mem_we", 32'(mem_we), 32'd1);
    checkOutput("force_mem_addr", 32'(mem_addr), 32'h00020);
    checkOutput("force_mem_wdata", 32'(mem_wdata), 32'h555555);
    next_cycle();
    applyStimulus(1'b0, '0, 1'b0, '0, '0);
    checkOutput("force_sc_valid", 32'(sc_valid), 32'd1);
    checkOutput("force_sc_repeat", 32'(sc_data), 32'hABCDEF);
    checkOutput("force_underrun", 32'(underrun_cnt), 32'd1);
    checkOutput("force_fifo_empty", 32'(mem_en), 32'd0);
    next_cycle();
`else
    checkOutput("nostarve_still_scan", 32'(mem_we), 32'd0);
    checkOutput("nostarve_underrun", 32'(underrun_cnt), 32'd0);
    next_cycle();
    applyStimulus(1'b0, '0, 1'b0, '0, '0);
    checkOutput("nostarve_sc_data", 32'(sc_data), 32'h123456);
    checkOutput("nostarve_late_we", 32'(mem_we), 32'd1);
    checkOutput("nostarve_late_addr", 32'(mem_addr), 32'h00020);
    checkOutput("nostarve_underrun_after", 32'(underrun_cnt), 32'd0);
    next_cycle();
`endif

    // Reset in the middle of a drain
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b1, '0, 1'b1, AW'(19'h00300 + i), DW'(24'h300000 + i));
      next_cycle();
    end
    applyStimulus(1'b0, '0, 1'b0, '0, '0);
    checkOutput("mid_first_pop_addr", 32'(mem_addr), 32'h00300);
    next_cycle();
    rst = 1'b1;
    applyStimulus(1'b0, '0, 1'b0, '0, '0);
    checkOutput("mid_rst_mem_en", 32'(mem_en), 32'd0);
    checkOutput("mid_rst_wr_ready", 32'(wr_ready), 32'd0);
    next_cycle();
    rst = 1'b0;
    applyStimulus(1'b0, '0, 1'b0, '0, '0);
    checkOutput("mid_post_wr_ready", 32'(wr_ready), 32'd1);
    checkOutput("mid_post_sc_valid", 32'(sc_valid), 32'd0);
    checkOutput("mid_post_underrun", 32'(underrun_cnt), 32'd0);
    seen_en = 1'b0;
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b0, '0, 1'b0, '0, '0);
      if (mem_en) seen_en = 1'b1;
      next_cycle();
    end
    checkOutput("mid_no_stale_write", 32'(seen_en), 32'd0);
    applyStimulus(1'b0, '0, 1'b1, 19'h003AA, 24'h777777);
    next_cycle();
    applyStimulus(1'b0, '0, 1'b0, '0, '0);
    checkOutput("mid_fresh_addr", 32'(mem_addr), 32'h003AA);
    checkOutput("mid_fresh_data", 32'(mem_wdata), 32'h777777);
    next_cycle();

    $display("test done: total=%0d bad=%0d", total_checks, bad_checks);
    $finish;
  end

endmodule
